// File: rtl/ctrl_campos_vga_if.sv
// ============================================================================
//  Module      : ctrl_campos_vga_if
//  Description : Button / RTC inputs and shadowed display selects exchanged
//                between the control sequencer and its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_campos_vga_if;
    logic       btn_prog;
    logic       btn_modo;
    logic       btn_izq;
    logic       btn_der;
    logic       alarma_req;
    logic       btn_apagar;
    logic       frame_fin;
    logic       P_HORA;
    logic       P_FECHA;
    logic       P_CRONO;
    logic [8:0] cam_co;
    logic       bit_alarma;
    logic       prog_activo;

    // Drives buttons/pulses, observes the display selects
    modport master (
        output btn_prog, btn_modo, btn_izq, btn_der, alarma_req, btn_apagar, frame_fin,
        input  P_HORA, P_FECHA, P_CRONO, cam_co, bit_alarma, prog_activo
    );

    // The sequencer itself
    modport slave (
        input  btn_prog, btn_modo, btn_izq, btn_der, alarma_req, btn_apagar, frame_fin,
        output P_HORA, P_FECHA, P_CRONO, cam_co, bit_alarma, prog_activo
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_campos_vga.sv
// ============================================================================
//  Module      : ctrl_campos_vga
//  Description : Sequences the VGA colouring stage: page selects, one-hot
//                field cursor and alarm flag. Display outputs are shadowed
//                and only update on frame_fin (vertical blank).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_campos_vga #(
    parameter int          TIMEOUT_W  = 27,
    parameter int          TIMEOUT    = 100000000,
    parameter logic [28:0] ALARMA_LEN = 29'd500000000
) (
    input  wire logic         reloj,
    input  wire logic         resetM,
    ctrl_campos_vga_if.slave  bus
);

    localparam logic [1:0] c_ST_REPOSO = 2'd0;
    localparam logic [1:0] c_ST_PROG   = 2'd1;
    localparam logic [1:0] c_ST_ALARMA = 2'd2;

    localparam logic [1:0] c_TG_HORA  = 2'd0;
    localparam logic [1:0] c_TG_FECHA = 2'd1;
    localparam logic [1:0] c_TG_CRONO = 2'd2;

    localparam logic [TIMEOUT_W-1:0] c_TIMEOUT = TIMEOUT_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // Button edge detection: one registered copy per button, and the
    // edge itself is registered so every decision uses aligned pulses.
    // Bit order: {apagar, prog, modo, izq, der}
    // ------------------------------------------------------------------
    logic [4:0] w_btn;
    logic [4:0] r_btn_q;
    logic [4:0] r_edge;
    logic       r_alarma_q;

    assign w_btn = {bus.btn_apagar, bus.btn_prog, bus.btn_modo, bus.btn_izq, bus.btn_der};

    logic w_e_apagar, w_e_prog, w_e_modo, w_e_izq, w_e_der, w_any_edge;
    assign w_e_apagar = r_edge[4];
    assign w_e_prog   = r_edge[3];
    assign w_e_modo   = r_edge[2];
    assign w_e_izq    = r_edge[1];
    assign w_e_der    = r_edge[0];
    assign w_any_edge = |r_edge;

    // Register button levels, their rising edges and the RTC alarm pulse
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            r_btn_q    <= 5'd0;
            r_edge     <= 5'd0;
            r_alarma_q <= 1'b0;
        end else begin
            r_btn_q    <= w_btn;
            r_edge     <= w_btn & ~r_btn_q;
            r_alarma_q <= bus.alarma_req;
        end
    end

    // ------------------------------------------------------------------
    // FSM and its data registers
    // ------------------------------------------------------------------
    logic [1:0]           r_state,  w_state_nx;
    logic [1:0]           r_target, w_target_nx;
    logic [1:0]           r_cursor, w_cursor_nx;
    logic [TIMEOUT_W-1:0] r_idle,   w_idle_nx;
    logic [28:0]          r_acnt,   w_acnt_nx;

    function automatic logic [1:0] f_next_target(input logic [1:0] t);
        case (t)
            c_TG_HORA:  f_next_target = c_TG_FECHA;
            c_TG_FECHA: f_next_target = c_TG_CRONO;
            default:    f_next_target = c_TG_HORA;
        endcase
    endfunction

    // State register with its cursor, target and counters
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            r_state  <= c_ST_REPOSO;
            r_target <= c_TG_HORA;
            r_cursor <= 2'd0;
            r_idle   <= '0;
            r_acnt   <= 29'd0;
        end else begin
            r_state  <= w_state_nx;
            r_target <= w_target_nx;
            r_cursor <= w_cursor_nx;
            r_idle   <= w_idle_nx;
            r_acnt   <= w_acnt_nx;
        end
    end

    // Next-state logic; the if/else order encodes the input priority
    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_cursor_nx = r_cursor;
        w_idle_nx   = r_idle;
        w_acnt_nx   = r_acnt;

        if (r_alarma_q) begin
            // Alarm wins from any state; a repeat request restarts the count
            w_state_nx  = c_ST_ALARMA;
            w_cursor_nx = 2'd0;
            w_idle_nx   = '0;
            w_acnt_nx   = 29'd0;
        end else begin
            case (r_state)
                c_ST_REPOSO: begin
                    w_idle_nx = '0;
                    w_acnt_nx = 29'd0;
                    if (w_e_apagar) begin
                        // Nothing to acknowledge; consumes the cycle
                    end else if (w_e_prog) begin
                        w_state_nx  = c_ST_PROG;
                        w_cursor_nx = 2'd0;
                    end else if (w_e_modo) begin
                        w_target_nx = f_next_target(r_target);
                    end
                end

                c_ST_PROG: begin
                    w_acnt_nx = 29'd0;
                    if (w_any_edge) begin
                        w_idle_nx = '0;
                    end else if (r_idle != c_TIMEOUT) begin
                        w_idle_nx = r_idle + 1'b1;
                    end

                    if (w_e_apagar) begin
                        // No alarm pending; only counts as activity
                    end else if (w_e_prog) begin
                        w_state_nx  = c_ST_REPOSO;
                        w_cursor_nx = 2'd0;
                    end else if (w_e_modo) begin
                        w_target_nx = f_next_target(r_target);
                        w_cursor_nx = 2'd0;
                    end else if (w_e_izq) begin
                        w_cursor_nx = (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
                    end else if (w_e_der) begin
                        w_cursor_nx = (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
                    end else if (r_idle == c_TIMEOUT) begin
                        w_state_nx  = c_ST_REPOSO;
                        w_cursor_nx = 2'd0;
                        w_idle_nx   = '0;
                    end
                end

                c_ST_ALARMA: begin
                    w_idle_nx   = '0;
                    w_cursor_nx = 2'd0;
                    if (w_e_apagar || (r_acnt == ALARMA_LEN)) begin
                        w_state_nx = c_ST_REPOSO;
                        w_acnt_nx  = 29'd0;
                    end else begin
                        w_acnt_nx = r_acnt + 29'd1;
                    end
                end

                default: begin
                    w_state_nx  = c_ST_REPOSO;
                    w_target_nx = c_TG_HORA;
                    w_cursor_nx = 2'd0;
                    w_idle_nx   = '0;
                    w_acnt_nx   = 29'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: next-display values derived from the current state
    // ------------------------------------------------------------------
    logic       w_hora_nx, w_fecha_nx, w_crono_nx, w_alarma_nx;
    logic [2:0] w_group;
    logic [8:0] w_cam_nx;

    // Decode page selects, cursor position and alarm flag
    always_comb begin
        w_hora_nx   = 1'b0;
        w_fecha_nx  = 1'b0;
        w_crono_nx  = 1'b0;
        w_cam_nx    = 9'd0;
        w_group     = 3'b100 >> r_cursor;
        w_alarma_nx = (r_state == c_ST_ALARMA);

        case (r_target)
            c_TG_FECHA: w_fecha_nx = 1'b1;
            c_TG_CRONO: w_crono_nx = 1'b1;
            default:    w_hora_nx  = 1'b1;
        endcase

        if (r_state == c_ST_PROG) begin
            case (r_target)
                c_TG_FECHA: w_cam_nx = {3'b000, w_group, 3'b000};
                c_TG_CRONO: w_cam_nx = {6'b000000, w_group};
                default:    w_cam_nx = {w_group, 6'b000000};
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers: display outputs only move during vertical blank
    // ------------------------------------------------------------------
    logic       r_p_hora, r_p_fecha, r_p_crono, r_bit_alarma;
    logic [8:0] r_cam_co;

    // Load next-display values on frame_fin
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            r_p_hora     <= 1'b1;
            r_p_fecha    <= 1'b0;
            r_p_crono    <= 1'b0;
            r_cam_co     <= 9'd0;
            r_bit_alarma <= 1'b0;
        end else if (bus.frame_fin) begin
            r_p_hora     <= w_hora_nx;
            r_p_fecha    <= w_fecha_nx;
            r_p_crono    <= w_crono_nx;
            r_cam_co     <= w_cam_nx;
            r_bit_alarma <= w_alarma_nx;
        end
    end

    assign bus.P_HORA      = r_p_hora;
    assign bus.P_FECHA     = r_p_fecha;
    assign bus.P_CRONO     = r_p_crono;
    assign bus.cam_co      = r_cam_co;
    assign bus.bit_alarma  = r_bit_alarma;
    // Unshadowed: RTC write gating must follow the state immediately
    assign bus.prog_activo = (r_state == c_ST_PROG);

endmodule

`default_nettype wire

// File: tb/tb_ctrl_campos_vga.sv
// ============================================================================
//  Module      : tb_ctrl_campos_vga
//  Description : Directed self-checking bench for ctrl_campos_vga
//                (TIMEOUT=16, ALARMA_LEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_campos_vga;

    logic reloj;
    logic resetM;
    int   n_tests = 0;
    int   n_fail  = 0;

    ctrl_campos_vga_if bus ();

    ctrl_campos_vga #(
        .TIMEOUT_W  (27),
        .TIMEOUT    (16),
        .ALARMA_LEN (29'd32)
    ) u_dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bus)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge reloj);
    endtask

    // One frame_fin pulse covering exactly one rising edge; returns at a negedge
    task automatic frame();
        @(negedge reloj) bus.frame_fin = 1'b1;
        @(negedge reloj) bus.frame_fin = 1'b0;
    endtask

    // 0=prog 1=modo 2=izq 3=der 4=apagar ; level held 2 cycles then released
    task automatic set_btn(input int which, input logic v);
        case (which)
            0: bus.btn_prog   = v;
            1: bus.btn_modo   = v;
            2: bus.btn_izq    = v;
            3: bus.btn_der    = v;
            default: bus.btn_apagar = v;
        endcase
    endtask

    task automatic press(input int which);
        @(negedge reloj) set_btn(which, 1'b1);
        cycles(2);
        set_btn(which, 1'b0);
        cycles(1);
    endtask

    initial begin
        bus.btn_prog = 0; bus.btn_modo = 0; bus.btn_izq = 0; bus.btn_der = 0;
        bus.alarma_req = 0; bus.btn_apagar = 0; bus.frame_fin = 0;
        resetM = 1'b1;
        cycles(3);
        resetM = 1'b0;

        // 1: reset values, then idle frames
        chk("rst_p_hora", bus.P_HORA, 1);
        chk("rst_cam", bus.cam_co, 0);
        chk("rst_prog", bus.prog_activo, 0);
        frame(); frame(); frame();
        chk("idle_p_hora", bus.P_HORA, 1);
        chk("idle_p_fecha", bus.P_FECHA, 0);
        chk("idle_p_crono", bus.P_CRONO, 0);
        chk("idle_cam", bus.cam_co, 0);
        chk("idle_alarma", bus.bit_alarma, 0);

        // 2: enter PROG, latency 2 cycles; cursor wrap left and back right
        @(negedge reloj) bus.btn_prog = 1'b1;
        cycles(1);
        chk("prog_edge1", bus.prog_activo, 0);
        cycles(1);
        chk("prog_edge2", bus.prog_activo, 1);
        chk("prog_cam_noframe", bus.cam_co, 0);
        bus.btn_prog = 1'b0;
        frame();
        chk("prog_cam", bus.cam_co, 9'b100000000);
        press(2);
        frame();
        chk("izq_wrap", bus.cam_co, 9'b001000000);
        press(3);
        frame();
        chk("der_wrap", bus.cam_co, 9'b100000000);

        // 3: modo twice -> CRONO, nothing visible until frame_fin
        press(1);
        press(1);
        chk("modo_hold_hora", bus.P_HORA, 1);
        chk("modo_hold_cam", bus.cam_co, 9'b100000000);
        frame();
        chk("modo_crono", bus.P_CRONO, 1);
        chk("modo_hora_off", bus.P_HORA, 0);
        chk("modo_cam", bus.cam_co, 9'b000000100);

        // 4: target FECHA, inactivity timeout back to REPOSO
        press(1);
        press(1);
        chk("to_still_prog", bus.prog_activo, 1);
        cycles(25);
        chk("to_prog_off", bus.prog_activo, 0);
        frame();
        chk("to_cam", bus.cam_co, 0);
        chk("to_p_fecha", bus.P_FECHA, 1);

        // 5: alarm + der in same cycle; acknowledge with apagar
        press(0);
        frame();
        chk("fecha_cam", bus.cam_co, 9'b000100000);
        @(negedge reloj) begin bus.alarma_req = 1'b1; bus.btn_der = 1'b1; end
        @(negedge reloj) bus.alarma_req = 1'b0;
        cycles(1);
        bus.btn_der = 1'b0;
        cycles(2);
        chk("al_prog_off", bus.prog_activo, 0);
        frame();
        chk("al_bit", bus.bit_alarma, 1);
        chk("al_cam", bus.cam_co, 0);
        press(4);
        frame();
        chk("ack_bit", bus.bit_alarma, 0);
        chk("ack_p_fecha", bus.P_FECHA, 1);
        chk("ack_prog", bus.prog_activo, 0);

        // 6: unacknowledged alarm expires after ALARMA_LEN
        @(negedge reloj) bus.alarma_req = 1'b1;
        @(negedge reloj) bus.alarma_req = 1'b0;
        cycles(3);
        frame();
        chk("len_bit_on", bus.bit_alarma, 1);
        cycles(15);
        frame();
        chk("len_bit_still", bus.bit_alarma, 1);
        cycles(30);
        frame();
        chk("len_bit_off", bus.bit_alarma, 0);

        // Reset in the middle of ALARMA clears outputs immediately
        @(negedge reloj) bus.alarma_req = 1'b1;
        @(negedge reloj) bus.alarma_req = 1'b0;
        cycles(3);
        frame();
        chk("rst2_bit_on", bus.bit_alarma, 1);
        resetM = 1'b1;
        #1;
        chk("rst2_bit", bus.bit_alarma, 0);
        chk("rst2_p_hora", bus.P_HORA, 1);
        chk("rst2_p_fecha", bus.P_FECHA, 0);
        cycles(2);
        resetM = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
